// File: rtl/wash_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// wash_cycle_ctrl
//
// Top-level washing sequencer. One accepted coin runs a program through
// FILL_WATER -> WASH -> RINSE (-> WASH -> RINSE when a double wash was
// requested) -> SPIN, then returns to IDLE and flags completion.
// Every phase lasts UNITS * (BASE_TICKS << freq_q) clock cycles. freq_q is
// the frequency code latched at program start:
//    00 = x1, 01 = x2, 10 = x4, 11 = x8.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   clk_freq     in   [1:0] frequency code, latched when a coin is accepted
//   coin_in      in   start request, level-sampled, accepted only in IDLE
//   double_wash  in   request one extra WASH+RINSE pass, latched with coin_in
//   timer_pause  in   freeze the phase timer, honoured only in SPIN
//   phase        out  [2:0] 0=IDLE 1=FILL_WATER 2=WASH 3=RINSE 4=SPIN
//                     (this is the FSM state register, exposed directly)
//   water_valve  out  1 only in FILL_WATER
//   motor_on     out  1 in WASH/RINSE/SPIN, forced 0 while SPIN is paused
//   wash_done    out  1 in IDLE after a completed program, cleared on the
//                     next accepted coin
//
// Start handshake: coin_in acts as a level "valid"; the controller is "ready"
// only while phase==IDLE. A coin is accepted on any rising edge where both
// hold; coin_in at any other time is simply dropped.
// ---------------------------------------------------------------------------
module wash_cycle_ctrl #(
   parameter int unsigned BASE_TICKS  = 60_000_000,
   parameter int unsigned FILL_UNITS  = 2,
   parameter int unsigned WASH_UNITS  = 5,
   parameter int unsigned RINSE_UNITS = 2,
   parameter int unsigned SPIN_UNITS  = 1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] clk_freq,
   input  logic       coin_in,
   input  logic       double_wash,
   input  logic       timer_pause,
   output logic [2:0] phase,
   output logic       water_valve,
   output logic       motor_on,
   output logic       wash_done
);

   localparam logic [2:0] PH_IDLE  = 3'd0;
   localparam logic [2:0] PH_FILL  = 3'd1;
   localparam logic [2:0] PH_WASH  = 3'd2;
   localparam logic [2:0] PH_RINSE = 3'd3;
   localparam logic [2:0] PH_SPIN  = 3'd4;

   localparam logic [CNT_W-1:0] BASE_C   = CNT_W'(BASE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [2:0]       phase_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       freq_q;
   logic             dbl_q;
   logic             done_q;

   logic [CNT_W-1:0] unit_ticks;
   logic [CNT_W-1:0] phase_units;
   logic [CNT_W-1:0] phase_limit;
   logic             last_cycle;
   logic             spin_paused;

   // One time unit in cycles, scaled by the frequency code latched at start.
   assign unit_ticks = BASE_C << freq_q;

   always_comb begin
      phase_units = '0;
      case (phase_q)
         PH_FILL:  phase_units = CNT_W'(FILL_UNITS);
         PH_WASH:  phase_units = CNT_W'(WASH_UNITS);
         PH_RINSE: phase_units = CNT_W'(RINSE_UNITS);
         PH_SPIN:  phase_units = CNT_W'(SPIN_UNITS);
         default:  phase_units = '0;
      endcase
   end

   assign phase_limit = phase_units * unit_ticks;
   assign last_cycle  = (cnt_q == (phase_limit - CNT_ONE));
   assign spin_paused = (phase_q == PH_SPIN) && timer_pause;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         freq_q  <= 2'b00;
         dbl_q   <= 1'b0;
         done_q  <= 1'b0;
      end else if (phase_q == PH_IDLE) begin
         if (coin_in) begin
            phase_q <= PH_FILL;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            freq_q  <= clk_freq;
            dbl_q   <= double_wash;
         end
      end else if (spin_paused) begin
         // Hold everything, including on the final SPIN cycle, so a pause
         // always delays completion rather than being skipped.
         cnt_q <= cnt_q;
      end else if (last_cycle) begin
         cnt_q <= '0;
         case (phase_q)
            PH_FILL:  phase_q <= PH_WASH;
            PH_WASH:  phase_q <= PH_RINSE;
            PH_RINSE: begin
               if (dbl_q) begin
                  // Only one extra pass: consume the flag on the way back.
                  phase_q <= PH_WASH;
                  dbl_q   <= 1'b0;
               end else begin
                  phase_q <= PH_SPIN;
               end
            end
            PH_SPIN: begin
               phase_q <= PH_IDLE;
               done_q  <= 1'b1;
            end
            default:  phase_q <= PH_IDLE;
         endcase
      end else begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign phase       = phase_q;
   assign water_valve = (phase_q == PH_FILL);
   assign motor_on    = ((phase_q == PH_WASH) || (phase_q == PH_RINSE) ||
                         (phase_q == PH_SPIN)) && !spin_paused;
   assign wash_done   = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wash_cycle_ctrl
//
// Bench for wash_cycle_ctrl with BASE_TICKS=2. The reference model is a
// timeline: when a coin is accepted it expands the whole program into a
// queue holding the expected phase for every cycle; each clock edge consumes
// one entry unless the head is SPIN and the pause is asserted. An empty
// queue means IDLE. Directed programs check total and SPIN durations, then a
// randomized run compares all outputs against the model every cycle.
// ---------------------------------------------------------------------------
module tb_wash_cycle_ctrl;

   localparam int BASE    = 2;
   localparam int U_FILL  = 2;
   localparam int U_WASH  = 5;
   localparam int U_RINSE = 2;
   localparam int U_SPIN  = 1;

   // clock / reset
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] clk_freq = 2'b00;
   logic       coin_in = 1'b0;
   logic       double_wash = 1'b0;
   logic       timer_pause = 1'b0;
   logic [2:0] phase;
   logic       water_valve;
   logic       motor_on;
   logic       wash_done;

   always #5 clk = ~clk;

   wash_cycle_ctrl #(
      .BASE_TICKS (BASE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_freq    (clk_freq),
      .coin_in     (coin_in),
      .double_wash (double_wash),
      .timer_pause (timer_pause),
      .phase       (phase),
      .water_valve (water_valve),
      .motor_on    (motor_on),
      .wash_done   (wash_done)
   );

   // scoreboard
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [2:0] exp_q[$];
   logic       exp_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int phase_len(input int units, input logic [1:0] f);
      return units * BASE * (1 << f);
   endfunction

   task automatic push_phase(input logic [2:0] ph, input int units, input logic [1:0] f);
      for (int i = 0; i < phase_len(units, f); i++) exp_q.push_back(ph);
   endtask

   task automatic model_start(input logic [1:0] f, input logic dbl);
      exp_q.delete();
      push_phase(3'd1, U_FILL, f);
      push_phase(3'd2, U_WASH, f);
      push_phase(3'd3, U_RINSE, f);
      if (dbl) begin
         push_phase(3'd2, U_WASH, f);
         push_phase(3'd3, U_RINSE, f);
      end
      push_phase(3'd4, U_SPIN, f);
      exp_done = 1'b0;
   endtask

   // One rising edge of the model, using the inputs applied before the edge.
   task automatic model_edge();
      if (exp_q.size() == 0) begin
         if (coin_in) model_start(clk_freq, double_wash);
      end else if (!(exp_q[0] == 3'd4 && timer_pause)) begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) exp_done = 1'b1;
      end
   endtask

   task automatic check_outputs();
      logic [2:0] ph;
      logic       exp_motor;
      ph = (exp_q.size() == 0) ? 3'd0 : exp_q[0];
      exp_motor = (ph >= 3'd2 && ph <= 3'd4) && !(ph == 3'd4 && timer_pause);
      check("phase", 32'(phase), 32'(ph));
      check("valve", 32'(water_valve), 32'(ph == 3'd1));
      check("motor", 32'(motor_on), 32'(exp_motor));
      check("done",  32'(wash_done), 32'(exp_done));
   endtask

   // driver tasks
   task automatic cyc(input logic c, input logic d, input logic [1:0] f, input logic p);
      @(negedge clk);
      coin_in = c; double_wash = d; clk_freq = f; timer_pause = p;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_done = 1'b0;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Starts a program and runs it to completion. Edges are numbered from 1
   // after the coin edge; f1 replaces f0 from edge fchg (0 = never), the
   // pause is held on edges [ps, ps+pl), the coin on edges [cs, cs+cl).
   // double_wash is inverted after the start edge to show it is ignored.
   task automatic run_prog(input string tag, input logic [1:0] f0, input logic [1:0] f1,
                           input int fchg, input logic dbl, input int ps, input int pl,
                           input int cs, input int cl, input int exp_total, input int exp_spin);
      int         i;
      int         spin;
      logic [1:0] f;
      spin = 0;
      cyc(1'b1, dbl, f0, 1'b0);
      check({tag, "/start"}, 32'(phase), 32'd1);
      check({tag, "/done_clr"}, 32'(wash_done), 32'd0);
      i = 0;
      while (wash_done !== 1'b1 && i < 2000) begin
         i++;
         f = (fchg > 0 && i >= fchg) ? f1 : f0;
         cyc((i >= cs && i < cs + cl), !dbl, f, (i >= ps && i < ps + pl));
         if (phase == 3'd4) spin++;
      end
      check({tag, "/total"}, 32'(i), 32'(exp_total));
      check({tag, "/spin"}, 32'(spin), 32'(exp_spin));
   endtask

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      do_reset();
      repeat (3) cyc(1'b0, 1'b0, 2'b00, 1'b0);

      // basic program at x1
      run_prog("p1_basic",  2'b00, 2'b00, 0, 1'b0, 0, 0, 0, 0, 20, 2);
      // x2, frequency code changed to x8 mid-WASH
      run_prog("p2_x2",     2'b01, 2'b11, 10, 1'b0, 0, 0, 0, 0, 40, 4);
      // double wash: exactly one extra pass
      run_prog("p3_dbl",    2'b00, 2'b00, 0, 1'b1, 0, 0, 0, 0, 34, 2);
      // pause over the last SPIN cycle for 5 edges
      run_prog("p4_pause",  2'b00, 2'b00, 0, 1'b0, 20, 5, 0, 0, 25, 7);
      // pause during WASH is ignored
      run_prog("p4_wpause", 2'b00, 2'b00, 0, 1'b0, 5, 4, 0, 0, 20, 2);

      // reset in the middle of WASH, then verify no resumption
      cyc(1'b1, 1'b0, 2'b00, 1'b0);
      repeat (7) cyc(1'b0, 1'b0, 2'b00, 1'b0);
      check("p5_in_wash", 32'(phase), 32'd2);
      do_reset();
      repeat (4) cyc(1'b0, 1'b0, 2'b00, 1'b0);
      check("p5_no_resume", 32'(phase), 32'd0);

      // coin pulsed during RINSE is ignored
      run_prog("p5_coin",   2'b00, 2'b00, 0, 1'b0, 0, 0, 15, 2, 20, 2);
      // coin held after done: restart on next edge, x8 SPIN of 16 cycles
      run_prog("p6_hold",   2'b11, 2'b11, 0, 1'b0, 0, 0, 1, 5000, 160, 16);
      repeat (2) cyc(1'b0, 1'b0, 2'b00, 1'b0);

      // randomized stimulus against the timeline model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            cyc(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
